// File: rtl/seatbelt_chime_seq.sv
// Seatbelt chime sequencer: qualifies the Alarm level, then plays a timed beep pattern
// on Buzzer, times out after MAX_BEEPS and re-arms once Alarm clears.
module seatbelt_chime_seq #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned ON_CYCLES   = 4,
    parameter int unsigned OFF_CYCLES  = 4,
    parameter int unsigned MAX_BEEPS   = 5,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Alarm,
    output logic             Buzzer,
    output logic             Active,
    output logic             TimedOut,
    output logic [CNT_W-1:0] BeepCount
);

    localparam int unsigned T_A   = (HOLD_CYCLES > ON_CYCLES) ? HOLD_CYCLES : ON_CYCLES;
    localparam int unsigned T_MAX = (T_A > OFF_CYCLES) ? T_A : OFF_CYCLES;
    localparam int unsigned TW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        QUAL,
        BEEP_ON,
        BEEP_OFF,
        DONE
    } state_t;

    state_t            state, state_n;
    logic [TW-1:0]     tmr, tmr_n;
    logic [CNT_W-1:0]  bc_n;
    logic              buzzer_n, active_n, timedout_n;

    // State, shared qual/beep timer, beep counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tmr       <= '0;
            BeepCount <= '0;
            Buzzer    <= 1'b0;
            Active    <= 1'b0;
            TimedOut  <= 1'b0;
        end else begin
            state     <= state_n;
            tmr       <= tmr_n;
            BeepCount <= bc_n;
            Buzzer    <= buzzer_n;
            Active    <= active_n;
            TimedOut  <= timedout_n;
        end
    end

    // Next state; Alarm low always wins over a timer expiry on the same edge
    always_comb begin
        state_n = state;
        tmr_n   = tmr;
        bc_n    = BeepCount;
        case (state)
            IDLE: begin
                if (Alarm) begin
                    if (HOLD_CYCLES <= 1) begin
                        state_n = BEEP_ON;
                        tmr_n   = '0;
                    end else begin
                        state_n = QUAL;
                        tmr_n   = TW'(1);
                    end
                end
            end
            QUAL: begin
                if (!Alarm) begin
                    state_n = IDLE;
                    tmr_n   = '0;
                    bc_n    = '0;
                end else if (tmr == TW'(HOLD_CYCLES - 1)) begin
                    state_n = BEEP_ON;
                    tmr_n   = '0;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            BEEP_ON: begin
                if (!Alarm) begin
                    state_n = IDLE;
                    tmr_n   = '0;
                    bc_n    = '0;
                end else if (tmr == TW'(ON_CYCLES - 1)) begin
                    state_n = BEEP_OFF;
                    tmr_n   = '0;
                    bc_n    = BeepCount + CNT_W'(1);
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            BEEP_OFF: begin
                if (!Alarm) begin
                    state_n = IDLE;
                    tmr_n   = '0;
                    bc_n    = '0;
                end else if (tmr == TW'(OFF_CYCLES - 1)) begin
                    state_n = (BeepCount == CNT_W'(MAX_BEEPS)) ? DONE : BEEP_ON;
                    tmr_n   = '0;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            DONE: begin
                if (!Alarm) begin
                    state_n = IDLE;
                    tmr_n   = '0;
                    bc_n    = '0;
                end
            end
            default: begin
                state_n = IDLE;
                tmr_n   = '0;
                bc_n    = '0;
            end
        endcase
    end

    // Output values follow the state being entered, so they register alongside it
    always_comb begin
        buzzer_n   = (state_n == BEEP_ON);
        active_n   = (state_n == BEEP_ON) || (state_n == BEEP_OFF);
        timedout_n = (state_n == DONE);
    end

endmodule
